// File: rtl/pixel_stream_pkg.sv
// Shared constants, state encoding and geometry helper for the pixel stream sequencer.
package pixel_stream_pkg;

  localparam int unsigned PIX_PER_BEAT    = 8;
  localparam int unsigned BEATS_PER_GROUP = 4;
  localparam int unsigned X_W             = 13;
  localparam int unsigned Y_W             = 12;
  localparam int unsigned GROUP_W         = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // x of the last beat in a line: 8 * (4 * groups - 1)
  function automatic logic [X_W-1:0] line_last_x(input logic [GROUP_W-1:0] groups);
    return X_W'(32'(groups) * PIX_PER_BEAT * BEATS_PER_GROUP - PIX_PER_BEAT);
  endfunction

endpackage

// File: rtl/pixel_seq_counter.sv
// Beat/line position counter with registered end-of-line and last-line flags.
module pixel_seq_counter
  import pixel_stream_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [GROUP_W-1:0] cfg_groups,
  input  logic [Y_W-1:0]     cfg_lines,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               eol,
  output logic               last_line
);

  logic [X_W-1:0] last_x_q;
  logic [Y_W-1:0] lines_q;

  // Flags are computed from next-state values so they line up with x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_x_q  <= '0;
      lines_q   <= '0;
      x         <= '0;
      y         <= '0;
      eol       <= 1'b0;
      last_line <= 1'b0;
    end else if (load) begin
      last_x_q  <= line_last_x(cfg_groups);
      lines_q   <= cfg_lines;
      x         <= '0;
      y         <= '0;
      eol       <= 1'b0;
      last_line <= (cfg_lines == Y_W'(1));
    end else if (advance) begin
      if (eol && last_line) begin
        x         <= '0;
        y         <= '0;
        eol       <= 1'b0;
        last_line <= 1'b0;
      end else if (eol) begin
        // A line is at least 4 beats, so the first beat of a line is never eol.
        x         <= '0;
        y         <= y + Y_W'(1);
        eol       <= 1'b0;
        last_line <= ((y + Y_W'(1)) == (lines_q - Y_W'(1)));
      end else begin
        x   <= x + X_W'(PIX_PER_BEAT);
        eol <= ((x + X_W'(PIX_PER_BEAT)) == last_x_q);
      end
    end
  end

endmodule

// File: rtl/pixel_stream_sequencer.sv
// Frame sequencer issuing beat coordinates to a pixel source/packer with valid/ready flow control.
// Optional PIXEL_SEQ_STALL_CNT_EN adds a saturating stall cycle counter output.
module pixel_stream_sequencer
  import pixel_stream_pkg::*;
(
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic               stop,
  input  logic [GROUP_W-1:0] cfg_groups,
  input  logic [Y_W-1:0]     cfg_lines,
  input  logic               in_ready,
  output logic               valid,
  output logic               sof,
  output logic               eol,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err
`ifdef PIXEL_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  state_t state;
  logic   cfg_ok;
  logic   accept;
  logic   xfer;
  logic   last_line;

  assign cfg_ok = (cfg_groups != '0) && (cfg_lines != '0);
  assign accept = (state == ST_IDLE) && start && !stop && cfg_ok;
  assign xfer   = valid && in_ready;

  pixel_seq_counter u_counter (
    .clk        (aclk),
    .rst        (areset),
    .load       (accept),
    .advance    (xfer),
    .cfg_groups (cfg_groups),
    .cfg_lines  (cfg_lines),
    .x          (x),
    .y          (y),
    .eol        (eol),
    .last_line  (last_line)
  );

  // Frame control FSM; valid is held through RUN and drops only after the final transfer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      valid      <= 1'b0;
      sof        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            if (cfg_ok) begin
              state <= ST_RUN;
              valid <= 1'b1;
              sof   <= 1'b1;
              busy  <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            sof <= 1'b0;
            if (eol && last_line) begin
              state      <= ST_IDLE;
              valid      <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIXEL_SEQ_STALL_CNT_EN
  // Cycles spent waiting on downstream, per frame.
  always_ff @(posedge aclk) begin
    if (areset || accept) begin
      stall_cnt <= '0;
    end else if (valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// Self-checking bench: frame-level beat queue model compared every cycle, plus directed literal checks.
module tb_pixel_stream_sequencer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic        stop;
  logic [7:0]  cfg_groups;
  logic [11:0] cfg_lines;
  logic        in_ready;
  logic        valid;
  logic        sof;
  logic        eol;
  logic [12:0] x;
  logic [11:0] y;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;
`ifdef PIXEL_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pixel_stream_sequencer dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .stop       (stop),
    .cfg_groups (cfg_groups),
    .cfg_lines  (cfg_lines),
    .in_ready   (in_ready),
    .valid      (valid),
    .sof        (sof),
    .eol        (eol),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
`ifdef PIXEL_SEQ_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int x;
    int y;
    bit sof;
    bit eol;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // Model state (written only by the compare process)
  beat_t       q[$];
  bit          running = 0;
  bit          exp_fd = 0;
  bit          exp_err = 0;
  bit          just_reset = 0;
  int unsigned stall_m = 0;

  // Observation log (written only by the compare process)
  int obs_x[128];
  int obs_y[128];
  bit obs_sof[128];
  bit obs_eol[128];
  int obs_n = 0;
  int fd_count = 0;
  int err_count = 0;
  int x8_cycles = 0;

  int exp_x1[8] = '{0, 8, 16, 24, 0, 8, 16, 24};
  int exp_y1[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge aclk) begin
    chk("valid", longint'(valid), longint'(running));
    chk("busy", longint'(busy), longint'(running));
    chk("frame_done", longint'(frame_done), longint'(exp_fd));
    chk("cfg_err", longint'(cfg_err), longint'(exp_err));
    if (running) begin
      chk("x", longint'(x), longint'(q[0].x));
      chk("y", longint'(y), longint'(q[0].y));
      chk("sof", longint'(sof), longint'(q[0].sof));
      chk("eol", longint'(eol), longint'(q[0].eol));
    end else if (just_reset) begin
      chk("reset_x", longint'(x), 0);
      chk("reset_y", longint'(y), 0);
      chk("reset_sof", longint'(sof), 0);
      chk("reset_eol", longint'(eol), 0);
    end
`ifdef PIXEL_SEQ_STALL_CNT_EN
    chk("stall_cnt", longint'(stall_cnt), longint'(stall_m));
`endif

    if (frame_done) fd_count++;
    if (cfg_err) err_count++;
    if (valid && x == 13'd8 && y == 12'd0) x8_cycles++;
    if (valid && in_ready && obs_n < 128) begin
      obs_x[obs_n]   = int'(x);
      obs_y[obs_n]   = int'(y);
      obs_sof[obs_n] = sof;
      obs_eol[obs_n] = eol;
      obs_n++;
    end

    exp_fd     = 0;
    exp_err    = 0;
    just_reset = areset;
    if (areset) begin
      running = 0;
      q.delete();
      stall_m = 0;
    end else if (running) begin
      if (in_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          running = 0;
          exp_fd  = 1;
        end
      end else if (stall_m != 32'hFFFF_FFFF) begin
        stall_m++;
      end
    end else if (start && !stop) begin
      if (cfg_groups == 0 || cfg_lines == 0) begin
        exp_err = 1;
      end else begin
        for (int l = 0; l < int'(cfg_lines); l++)
          for (int b = 0; b < 4 * int'(cfg_groups); b++)
            q.push_back('{x: 8 * b, y: l, sof: (l == 0 && b == 0),
                          eol: (b == 4 * int'(cfg_groups) - 1)});
        running = 1;
        stall_m = 0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    int i;
    base = fd_count;
    i = 0;
    while (fd_count == base && i < budget) begin
      step();
      i++;
    end
    chk("frame_done_seen", longint'(fd_count > base), 1);
  endtask

  initial begin
    int b0;
    int f0;
    int e0;
    int x80;
    int n;
    areset     = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    cfg_groups = 8'd1;
    cfg_lines  = 12'd2;
    in_ready   = 1'b1;
    step(2);
    areset = 1'b0;
    step();

    // Basic 1x2 frame
    b0 = obs_n;
    pulse_start();
    wait_done(50);
    step();
    chk("t1_beats", obs_n - b0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_x", obs_x[b0+i], exp_x1[i]);
      chk("t1_y", obs_y[b0+i], exp_y1[i]);
      chk("t1_eol", obs_eol[b0+i], (i == 3 || i == 7) ? 1 : 0);
      chk("t1_sof", obs_sof[b0+i], (i == 0) ? 1 : 0);
    end

    // Stall for 3 cycles on the second beat
    b0  = obs_n;
    x80 = x8_cycles;
    pulse_start();
    step();
    in_ready = 1'b0;
    step(3);
    in_ready = 1'b1;
    wait_done(50);
    step();
    chk("t2_beats", obs_n - b0, 8);
    for (int i = 0; i < 8; i++) chk("t2_x", obs_x[b0+i], exp_x1[i]);
    chk("t2_x8_hold", x8_cycles - x80, 4);
`ifdef PIXEL_SEQ_STALL_CNT_EN
    chk("t2_stall_cnt", longint'(stall_cnt), 3);
`endif

    // Zero-line config is rejected
    e0 = err_count;
    cfg_lines = 12'd0;
    pulse_start();
    step(2);
    chk("t3_cfg_err", err_count - e0, 1);
    chk("t3_valid", longint'(valid), 0);
    chk("t3_busy", longint'(busy), 0);

    // Config and start changes mid-frame are ignored
    b0 = obs_n;
    cfg_groups = 8'd2;
    cfg_lines  = 12'd3;
    pulse_start();
    step(5);
    cfg_groups = 8'd1;
    cfg_lines  = 12'd1;
    pulse_start();
    wait_done(200);
    step();
    chk("t4_beats", obs_n - b0, 24);
    n = 0;
    for (int i = b0; i < obs_n; i++) if (obs_eol[i] && obs_x[i] == 56) n++;
    chk("t4_eol_at_56", n, 3);

    // Reset mid-frame abandons it
    cfg_groups = 8'd1;
    cfg_lines  = 12'd2;
    f0 = fd_count;
    pulse_start();
    step(4);
    areset = 1'b1;
    step();
    areset = 1'b0;
    step(3);
    chk("t5_no_done", fd_count - f0, 0);
    b0 = obs_n;
    pulse_start();
    wait_done(50);
    step();
    chk("t5_beats", obs_n - b0, 8);
    chk("t5_sof", obs_sof[b0], 1);
    chk("t5_x0", obs_x[b0], 0);
    chk("t5_y0", obs_y[b0], 0);

    // Stop lets the frame finish but blocks the next start
    cfg_lines = 12'd1;
    f0 = fd_count;
    pulse_start();
    stop = 1'b1;
    wait_done(50);
    step();
    chk("t6_done", fd_count - f0, 1);
    start = 1'b1;
    step(4);
    start = 1'b0;
    chk("t6_blocked_valid", longint'(valid), 0);
    chk("t6_blocked_done", fd_count - f0, 1);
    stop = 1'b0;
    pulse_start();
    wait_done(50);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_stream_sequencer.md
PIXEL_STREAM_SEQUENCER -- requirements
Module: pixel_stream_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 aclk  in  1  clock; all logic on rising edge.
REQ-003 areset  in  1  synchronous active-high reset.
REQ-004 start  in  1  frame start request; sampled only in IDLE.
REQ-005 stop  in  1  level; when high, no further frame starts.
REQ-006 cfg_groups  in  8  line length in 4-beat groups (1 group = 4 beats x 8 px = 32 px).
REQ-007 cfg_lines  in  12  lines per frame.
REQ-008 in_ready  in  1  downstream packer input ready.
REQ-009 valid  out  1  beat valid to pixel source/packer.
REQ-010 sof  out  1  first beat of frame.
REQ-011 eol  out  1  last beat of line.
REQ-012 x  out  13  pixel index of first pixel in current beat (multiple of 8).
REQ-013 y  out  12  line index of current beat.
REQ-014 busy  out  1  high in RUN.
REQ-015 frame_done  out  1  one-cycle pulse after last beat of frame accepted.
REQ-016 cfg_err  out  1  one-cycle pulse when start rejected for zero config.

Function
REQ-017 SHALL implement states IDLE and RUN.
REQ-018 IDLE: start=1, stop=0, cfg_groups!=0, cfg_lines!=0 -> latch cfg, go RUN next cycle with x=0, y=0, valid=1, sof=1.
REQ-019 IDLE: start=1 with cfg_groups==0 or cfg_lines==0 -> stay IDLE, cfg_err=1 for one cycle.
REQ-020 Beat transfer SHALL occur on cycle with valid=1 and in_ready=1; valid only deasserts after a transfer.
REQ-021 While valid=1 and in_ready=0, valid, sof, eol, x and y SHALL hold stable.
REQ-022 After each transfer, x SHALL advance by 8; beat after eol sets x=0 and y=y+1.
REQ-023 eol SHALL be 1 exactly on beat index 4*cfg_groups-1 of each line, so eol always falls on the 4th beat of a group.
REQ-024 sof SHALL be 1 only on beat x=0, y=0, and cleared after that beat transfers.
REQ-025 Transfer of eol beat with y==cfg_lines-1 SHALL move to IDLE next cycle, valid=0, frame_done=1 for that cycle.
REQ-026 start or cfg changes during RUN SHALL be ignored; latched cfg used for whole frame.
REQ-027 stop during RUN SHALL NOT truncate the frame; it blocks only the next start.
REQ-028 Counters SHALL not wrap: max x = 8*(4*255-1)=8152 fits 13 bits; y max 4094.
REQ-029 Outputs SHALL be registered; no combinational path from in_ready to valid.

Reset
REQ-030 areset SHALL force IDLE, valid=0, sof=0, eol=0, x=0, y=0, busy=0, frame_done=0, cfg_err=0 on next edge.
REQ-031 areset mid-frame SHALL abandon the frame; no frame_done issued.

Configuration
REQ-032 Macro PIXEL_SEQ_STALL_CNT_EN SHALL, when defined, add output stall_cnt [31:0]: counts cycles with valid=1, in_ready=0; cleared by areset and on each accepted start; saturates at 0xFFFFFFFF.
REQ-033 Without PIXEL_SEQ_STALL_CNT_EN, stall_cnt port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-034 Package pixel_stream_pkg SHALL hold PIX_PER_BEAT=8, BEATS_PER_GROUP=4, X_W=13, Y_W=12, GROUP_W=8 and the state enum.
REQ-035 Sub-module pixel_seq_counter SHALL implement beat/line counting with eol/last-line flags; top holds FSM and handshake.

Verification
REQ-036 cfg_groups=1, cfg_lines=2, in_ready=1, start pulse -> 8 beats, x=0,8,16,24 per line, eol on x=24, sof on first only, frame_done 1 cycle after 8th beat.
REQ-037 Same config, in_ready low for 3 cycles on beat 2 -> x=8 held 3 cycles, no beat lost or duplicated, stall_cnt=3 when macro defined.
REQ-038 start with cfg_lines=0 -> cfg_err pulse, valid stays 0, busy 0.
REQ-039 cfg_groups=2, cfg_lines=3; change cfg and pulse start mid-frame -> still 24 beats at original cfg, eol at x=56.
REQ-040 areset asserted at beat 5 of a frame -> next cycle all outputs zero, IDLE; new start gives sof at x=0,y=0.
REQ-041 stop=1 during frame -> frame completes with frame_done; subsequent start ignored until stop=0.
